// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, PC-select and state definitions for the CPU sequencer
package cpu_pkg;

    localparam logic [5:0] OP_LW  = 6'b010000;
    localparam logic [5:0] OP_SW  = 6'b010001;
    localparam logic [5:0] OP_BEQ = 6'b100000;
    localparam logic [5:0] OP_JMP = 6'b100001;

    localparam logic [1:0] PCSEL_SEQ = 2'd0;
    localparam logic [1:0] PCSEL_BR  = 2'd1;
    localparam logic [1:0] PCSEL_JMP = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_JMP, CLS_ILL
    } op_class_t;

    function automatic op_class_t op_class(input logic [5:0] o);
        if (o[5:4] == 2'b00) return CLS_ALU;
        case (o)
            OP_LW:   return CLS_LW;
            OP_SW:   return CLS_SW;
            OP_BEQ:  return CLS_BEQ;
            OP_JMP:  return CLS_JMP;
            default: return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/cpu_seq_ctrl_if.sv
// rtl/cpu_seq_ctrl_if.sv - instruction/data memory handshake bundle
interface cpu_seq_ctrl_if;
    logic imem_req;
    logic imem_ack;
    logic ir_load;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (output imem_req, ir_load, dmem_req, dmem_we,
                    input  imem_ack, dmem_ack);
    modport slave  (input  imem_req, ir_load, dmem_req, dmem_we,
                    output imem_ack, dmem_ack);
endinterface

// File: rtl/cpu_seq_ctrl_mem_wait_timer.sv
// rtl/cpu_seq_ctrl_mem_wait_timer.sv - memory wait counter with expiry flag, shared by fetch and data waits
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Flags the final waiting cycle so the FSM can leave on the same edge the count reaches the limit.
    assign expired = (count_q == LAST_WAIT);

endmodule

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle IF/ID/EX/MEM/WB sequencer; optional counters under CPU_SEQ_PERF_EN
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic [5:0]  op,
    input  logic        zero,
    cpu_seq_ctrl_if.master mem,
    output logic        alu_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        reg_update,
    output logic        wb_sel,
    output logic        busy,
    output logic        fault,
    output logic        illegal_op
`ifdef CPU_SEQ_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_t    state_q, state_d;
    logic [5:0] op_q;
    logic      illegal_q;
    logic      set_illegal;
    logic      tmr_clr, tmr_inc, tmr_expired;
    logic      instr_end;
    op_class_t cls_q;

    assign cls_q      = op_class(op_q);
    assign illegal_op = illegal_q;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) op_q <= op;
            if (set_illegal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem.imem_req = 1'b0;
        mem.ir_load  = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        alu_en       = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = PCSEL_SEQ;
        reg_update   = 1'b0;
        wb_sel       = 1'b0;
        busy         = 1'b0;
        fault        = 1'b0;
        set_illegal  = 1'b0;
        tmr_clr      = 1'b1;
        tmr_inc      = 1'b0;
        instr_end    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_IF;
            end
            S_IF: begin
                busy         = 1'b1;
                mem.imem_req = 1'b1;
                tmr_clr      = mem.imem_ack;
                tmr_inc      = !mem.imem_ack;
                // Ack is checked first so a late ack on the last allowed cycle still completes.
                if (mem.imem_ack) begin
                    mem.ir_load = 1'b1;
                    state_d     = S_ID;
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_ID: begin
                busy = 1'b1;
                if (op_class(op) == CLS_ILL) begin
                    set_illegal = 1'b1;
                    state_d     = S_FAULT;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                busy   = 1'b1;
                alu_en = 1'b1;
                case (cls_q)
                    CLS_ALU: state_d = S_WB;
                    CLS_LW,
                    CLS_SW:  state_d = S_MEM;
                    CLS_BEQ: begin
                        pc_en     = 1'b1;
                        pc_sel    = zero ? PCSEL_BR : PCSEL_SEQ;
                        instr_end = 1'b1;
                    end
                    CLS_JMP: begin
                        pc_en     = 1'b1;
                        pc_sel    = PCSEL_JMP;
                        instr_end = 1'b1;
                    end
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                busy         = 1'b1;
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (cls_q == CLS_SW);
                tmr_clr      = mem.dmem_ack;
                tmr_inc      = !mem.dmem_ack;
                if (mem.dmem_ack) begin
                    if (cls_q == CLS_SW) begin
                        pc_en     = 1'b1;
                        instr_end = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_WB: begin
                busy       = 1'b1;
                reg_update = 1'b1;
                wb_sel     = (cls_q == CLS_LW);
                pc_en      = 1'b1;
                instr_end  = 1'b1;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (instr_end) state_d = halt_req ? S_IDLE : S_IF;
    end

`ifdef CPU_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            if (busy)      cyc_cnt   <= cyc_cnt + 32'd1;
            if (instr_end) instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - directed scoreboard bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;

    localparam logic [12:0] IMQ = 13'h1000;
    localparam logic [12:0] IRL = 13'h0800;
    localparam logic [12:0] DMQ = 13'h0400;
    localparam logic [12:0] DWE = 13'h0200;
    localparam logic [12:0] ALU = 13'h0100;
    localparam logic [12:0] PCE = 13'h0080;
    localparam logic [12:0] SJP = 13'h0040;
    localparam logic [12:0] SBR = 13'h0020;
    localparam logic [12:0] REG = 13'h0010;
    localparam logic [12:0] WBS = 13'h0008;
    localparam logic [12:0] BSY = 13'h0004;
    localparam logic [12:0] FLT = 13'h0002;
    localparam logic [12:0] ILL = 13'h0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic [5:0]  op = 6'd0;
    logic        zero = 1'b0;
    logic        alu_en, pc_en, reg_update, wb_sel, busy, fault, illegal_op;
    logic [1:0]  pc_sel;
`ifdef CPU_SEQ_PERF_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];

    cpu_seq_ctrl_if mem_if ();

    cpu_seq_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .halt_req   (halt_req),
        .op         (op),
        .zero       (zero),
        .mem        (mem_if),
        .alu_en     (alu_en),
        .pc_en      (pc_en),
        .pc_sel     (pc_sel),
        .reg_update (reg_update),
        .wb_sel     (wb_sel),
        .busy       (busy),
        .fault      (fault),
        .illegal_op (illegal_op)
`ifdef CPU_SEQ_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] observed();
        return {mem_if.imem_req, mem_if.ir_load, mem_if.dmem_req, mem_if.dmem_we,
                alu_en, pc_en, pc_sel, reg_update, wb_sel, busy, fault, illegal_op};
    endfunction

    // Inputs are set by the caller at a falling edge; outputs are sampled 2 ns later.
    task automatic step(input string tag, input logic [12:0] expv);
        logic [12:0] e;
        logic [12:0] o;
        string       t;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        #2;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
        @(negedge clk);
    endtask

    task automatic fetch_decode(input logic [5:0] opc);
        mem_if.imem_ack = 1'b1;
        step("if", IMQ | IRL | BSY);
        mem_if.imem_ack = 1'b0;
        op = opc;
        step("id", BSY);
    endtask

    initial begin
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;
        @(negedge clk);
        step("reset", 13'h0);
        rst_n = 1'b1;

        // ALU with halt: four busy cycles then back to IDLE
        start = 1'b1;
        step("idle_start", 13'h0);
        start = 1'b0;
        fetch_decode(6'b000001);
        halt_req = 1'b1;
        step("alu_ex", ALU | BSY);
        step("alu_wb", REG | PCE | BSY);
        halt_req = 1'b0;
        step("halted_idle", 13'h0);
`ifdef CPU_SEQ_PERF_EN
        vectors++;
        assert (cyc_cnt === 32'd4) else begin
            miscompares++;
            $error("FAIL cyc_cnt observed=%0d expected=4", cyc_cnt);
        end
        vectors++;
        assert (instr_cnt === 32'd1) else begin
            miscompares++;
            $error("FAIL instr_cnt observed=%0d expected=1", instr_cnt);
        end
`endif
        step("still_idle", 13'h0);

        // ALU without halt continues straight into the next fetch
        start = 1'b1;
        step("restart", 13'h0);
        start = 1'b0;
        fetch_decode(6'b000001);
        start = 1'b1;
        step("alu_ex2", ALU | BSY);
        start = 1'b0;
        step("alu_wb2", REG | PCE | BSY);

        fetch_decode(6'b100000);
        zero = 1'b1;
        step("beq_taken", ALU | PCE | SBR | BSY);
        fetch_decode(6'b100000);
        zero = 1'b0;
        step("beq_not_taken", ALU | PCE | BSY);
        fetch_decode(6'b100001);
        step("jmp_ex", ALU | PCE | SJP | BSY);

        // LW with three wait cycles on the data port
        fetch_decode(6'b010000);
        step("lw_ex", ALU | BSY);
        for (int i = 0; i < 3; i++) step("lw_mem_wait", DMQ | BSY);
        mem_if.dmem_ack = 1'b1;
        step("lw_mem_ack", DMQ | BSY);
        mem_if.dmem_ack = 1'b0;
        step("lw_wb", REG | WBS | PCE | BSY);

        fetch_decode(6'b010001);
        step("sw_ex", ALU | BSY);
        mem_if.dmem_ack = 1'b1;
        step("sw_mem", DMQ | DWE | PCE | BSY);
        mem_if.dmem_ack = 1'b0;

        // Fetch timeout: 16 waiting cycles, FAULT on the 17th
        for (int i = 0; i < 16; i++) step("if_wait", IMQ | BSY);
        start = 1'b1;
        step("to_fault", FLT);
        step("fault_sticky", FLT);
        start = 1'b0;
        mem_if.imem_ack = 1'b1;
        step("fault_ignores_ack", FLT);
        mem_if.imem_ack = 1'b0;
        rst_n = 1'b0;
        step("fault_reset", 13'h0);
        rst_n = 1'b1;

        // Illegal opcode
        start = 1'b1;
        step("ill_start", 13'h0);
        start = 1'b0;
        fetch_decode(6'b111111);
        step("ill_fault", FLT | ILL);
        step("ill_sticky", FLT | ILL);
        rst_n = 1'b0;
        step("ill_reset", 13'h0);
        rst_n = 1'b1;

        // Async reset while a load waits in MEM
        start = 1'b1;
        step("lw2_start", 13'h0);
        start = 1'b0;
        fetch_decode(6'b010000);
        step("lw2_ex", ALU | BSY);
        step("lw2_mem", DMQ | BSY);
        rst_n = 1'b0;
        mem_if.dmem_ack = 1'b1;
        step("mem_async_reset", 13'h0);
        rst_n = 1'b1;
        mem_if.dmem_ack = 1'b0;
        step("post_reset_idle", 13'h0);
        step("post_reset_idle2", 13'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue CPU datapath: instruction register, decode/register file, ALU, PC, data memory.
- Walks each instruction through fetch, decode, execute, memory and write-back.
- Drives the stage enables, PC select and the decode stage's reg_update write strobe.
- Handshakes with the instruction and data memory ports, and traps illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: max cycles to wait for imem_ack/dmem_ack before FAULT.
- TO_W, 5: timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- halt_req  in  1  stop at next instruction boundary.
- op  in  6  opcode from decode (ir[31:26]).
- zero  in  1  ALU result == 0; BEQ operand A = Ri^Rj.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid this cycle.
- ir_load  out  1  load instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store (SW), 0 = load (LW); valid with dmem_req.
- dmem_ack  in  1  data access complete.
- alu_en  out  1  ALU operand/result register enable.
- pc_en  out  1  PC update strobe.
- pc_sel  out  2  0 = PC+4, 1 = branch (PC+4+Imm<<2), 2 = jump (Imm<<2).
- reg_update  out  1  register-file write enable to decode.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- busy  out  1  instruction in flight.
- fault  out  1  sticky error flag.
- illegal_op  out  1  sticky: fault cause was an undefined opcode.

Behaviour:
- Reset (async, rst_n=0): state IDLE, op_q=0, timeout counter 0. All outputs 0, including fault and illegal_op.
- Outputs are Moore decodes of state plus op_q/zero, with no combinational path from start or halt_req. Handshake outputs additionally use imem_ack/dmem_ack (ir_load = IF & imem_ack).
- Opcode classes (op_q):
  - ALU: op[5:4]=00
  - LW: 010000
  - SW: 010001
  - BEQ: 100000
  - JMP: 100001
  - anything else is illegal.
- IDLE: start=1 -> IF. busy=0.
- IF: imem_req=1 held until imem_ack.
  - On ack: ir_load=1 for that single cycle -> ID.
  - Counter increments each waiting cycle; reaching MEM_TIMEOUT without ack -> FAULT.
- ID: one cycle; op_q <= op.
  - Illegal op -> FAULT with illegal_op<=1.
  - Otherwise -> EX.
- EX: alu_en=1.
  - ALU -> WB.
  - LW/SW -> MEM.
  - BEQ: pc_en=1, pc_sel = zero ? 1 : 0; instruction ends.
  - JMP: pc_en=1, pc_sel=2; instruction ends.
- MEM: dmem_req=1, dmem_we=(SW), held until dmem_ack.
  - LW on ack -> WB.
  - SW on ack: pc_en=1, pc_sel=0; instruction ends.
  - Timeout -> FAULT (illegal_op stays 0).
- WB: reg_update=1 for exactly one cycle; wb_sel=(LW); pc_en=1, pc_sel=0; instruction ends. Decode samples reg_update on the falling edge inside this cycle.
- Instruction end: next state is IDLE if halt_req=1 that cycle, else IF.
- FAULT: all strobes 0, fault=1, busy=0; leaves only on rst_n.
- Timeout counter clears on entry to IF/MEM and on ack.
- busy=1 in IF, ID, EX, MEM, WB.
- Simultaneous ack and timeout expiry: ack wins.
- start while busy: ignored.
- Reset mid-instruction: immediate return to IDLE; no partial reg_update or pc_en pulse.
- Cycle counts with zero-wait memory (ack in first request cycle):
  - ALU: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ/JMP: 3 cycles

Optional Feature:
- Macro CPU_SEQ_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[31:0] (increments every cycle while busy) and instr_cnt[31:0] (increments at each instruction end).
  - Both reset to 0, wrap modulo 2^32, and freeze in FAULT.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_BEQ, OP_JMP
  - PC select constants PCSEL_SEQ/BR/JMP
  - state enum IDLE/IF/ID/EX/MEM/WB/FAULT
- One natural sub-module: mem_wait_timer, the loadable timeout counter with expiry flag, shared by the IF and MEM waits.

Test Plan:
- ALU op=000001, zero-wait memory, start pulse: imem_req cycle 1, ir_load cycle 1, alu_en cycle 3, reg_update and pc_en (pc_sel=0) cycle 4 only, then IF.
- BEQ op=100000: with zero=1 -> pc_sel=1 in EX; with zero=0 -> pc_sel=0. No reg_update in either case. JMP -> pc_sel=2.
- LW op=010000, dmem_ack delayed 3 cycles: dmem_req=1 and dmem_we=0 for 4 cycles, then WB with wb_sel=1 and reg_update=1. SW op=010001: dmem_we=1 and no reg_update.
- imem_ack never asserted, MEM_TIMEOUT=16: FAULT entered at cycle 17, fault=1, illegal_op=0, busy=0, persists until rst_n.
- op=111111: FAULT after ID with illegal_op=1. Additionally, rst_n pulsed low during MEM: all outputs 0 asynchronously, state IDLE.
- halt_req=1 during EX of ALU op: completes WB, returns to IDLE. With CPU_SEQ_PERF_EN: instr_cnt=1, cyc_cnt=4.
